imem_loader: RTL and testbench

- Parametrised instruction-memory loader and boot sequencer that sits between the bench/host and the single-cycle `cpu` core.
- Owns the instruction memory.
- Zero-fills the memory after reset, then accepts program words over a valid/ready load port, in explicit-address or auto-increment mode.
- Holds the core in reset for a programmable number of cycles after loading, then serves combinational instruction fetches.
- Supports re-load without a system reset, and flags misaligned or out-of-range writes.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/imem_array.sv | 22 ++
 rtl/imem_loader.sv | 163 ++++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the loader/boot sequencer and its memories.
package cpu_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    HOLD  = 2'd2,
    RUN   = 2'd3
  } loader_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);
  localparam int unsigned NOP_WORD   = 0;

  // Word-index width for a memory of the given depth.
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module imem_array #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata_c
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader and boot sequencer: clears memory, accepts program
// words, holds the core in reset, then serves combinational fetches.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     initialize,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic                     ld_auto,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic [DATA_W-1:0]        fetch_data,
  output logic                     cpu_rst,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic                     err_align,
  output logic                     err_range
);

  localparam int unsigned IDX_W  = idx_width(DEPTH);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  loader_state_e     r_state;
  loader_state_e     w_state_nxt;
  logic [CNT_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_clr_idx;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0]  r_load_count;
  logic              r_err_align;
  logic              r_err_range;
  logic              r_cpu_rst;
  logic              r_busy;

  logic [ADDR_W-1:0] w_ld_idx;
  logic [ADDR_W-1:0] w_fetch_idx;
  logic              w_wr_ok;
  logic              w_set_align;
  logic              w_set_range;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_mem_rdata;
  logic              w_fetch_hit;

  // Handshake closes in the same cycle initialize drops, so the exit cycle never accepts.
  assign ld_ready = (r_state == LOAD) && initialize;

  // Next state plus write-port steering and error strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_ok     = 1'b0;
    w_set_align = 1'b0;
    w_set_range = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = r_clr_idx;
    w_mem_wdata = '0;
    w_ld_idx    = ld_auto ? ADDR_W'(r_ptr) : (ld_addr >> WORD_SHIFT);

    case (r_state)
      CLEAR: begin
        w_mem_we = 1'b1;
        if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_nxt = initialize ? LOAD : HOLD;
      end
      LOAD: begin
        if (!initialize) begin
          w_state_nxt = HOLD;
        end else if (ld_valid) begin
          if (!ld_auto && (ld_addr[1:0] != 2'b00)) begin
            w_set_align = 1'b1;
          end else if (w_ld_idx >= ADDR_W'(DEPTH)) begin
            w_set_range = 1'b1;
          end else begin
            w_wr_ok     = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_waddr = w_ld_idx[IDX_W-1:0];
            w_mem_wdata = ld_data;
          end
        end
      end
      HOLD: begin
        if (initialize)                                    w_state_nxt = LOAD;
        else if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1))   w_state_nxt = RUN;
      end
      RUN: begin
        if (initialize) w_state_nxt = LOAD;
      end
      default: w_state_nxt = CLEAR;
    endcase

    if (rst) w_mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= CLEAR;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_clr_idx    <= '0;
      r_hold_cnt   <= '0;
      r_load_count <= '0;
      r_err_align  <= 1'b0;
      r_err_range  <= 1'b0;
      r_cpu_rst    <= 1'b1;
      r_busy       <= 1'b1;
    end else begin
      r_cpu_rst <= (w_state_nxt != RUN);
      r_busy    <= (w_state_nxt != RUN);

      if (r_state == CLEAR) r_clr_idx <= r_clr_idx + IDX_W'(1);

      if ((r_state == HOLD) && (w_state_nxt == HOLD)) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      else                                            r_hold_cnt <= '0;

      // A fresh load session from RUN restarts the pointer and count; memory is kept.
      if ((r_state == RUN) && (w_state_nxt == LOAD)) begin
        r_ptr        <= '0;
        r_load_count <= '0;
      end else if (w_wr_ok) begin
        r_ptr <= w_ld_idx[CNT_W-1:0] + CNT_W'(1);
        if (r_load_count != '1) r_load_count <= r_load_count + CNT_W'(1);
      end

      if (w_set_align) r_err_align <= 1'b1;
      if (w_set_range) r_err_range <= 1'b1;
    end
  end

  imem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_mem_we),
    .i_waddr   (w_mem_waddr),
    .i_wdata   (w_mem_wdata),
    .i_raddr   (w_fetch_idx[IDX_W-1:0]),
    .o_rdata_c (w_mem_rdata)
  );

  // Out-of-range or non-RUN fetches return a NOP; byte offset bits are dropped.
  assign w_fetch_idx = fetch_addr >> WORD_SHIFT;
  assign w_fetch_hit = (r_state == RUN) && (w_fetch_idx < ADDR_W'(DEPTH));
  assign fetch_data  = w_fetch_hit ? w_mem_rdata : DATA_W'(NOP_WORD);

  assign cpu_rst    = r_cpu_rst;
  assign busy       = r_busy;
  assign load_count = r_load_count;
  assign err_align  = r_err_align;
  assign err_range  = r_err_range;

endmodule

// File: tb/tb_imem_loader.sv
// Directed, self-checking bench for imem_loader (default build plus a DEPTH=4 build).
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build: DEPTH=64, HOLD_CYCLES=4
  logic        rst, initialize, ld_valid, ld_ready, ld_auto;
  logic [31:0] ld_addr, ld_data, fetch_addr, fetch_data;
  logic        cpu_rst, busy, err_align, err_range;
  logic [6:0]  load_count;

  // Small build: DEPTH=4, HOLD_CYCLES=2
  logic        s_rst, s_init, s_valid, s_ready, s_auto;
  logic [31:0] s_addr, s_data, s_fetch, s_fdata;
  logic        s_cpu_rst, s_busy, s_ea, s_er;
  logic [2:0]  s_cnt;

  imem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .initialize(initialize), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_auto(ld_auto), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .cpu_rst(cpu_rst), .busy(busy), .load_count(load_count),
    .err_align(err_align), .err_range(err_range)
  );

  imem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .HOLD_CYCLES(2)) dut_s (
    .clk(clk), .rst(s_rst), .initialize(s_init), .ld_valid(s_valid), .ld_ready(s_ready),
    .ld_auto(s_auto), .ld_addr(s_addr), .ld_data(s_data), .fetch_addr(s_fetch),
    .fetch_data(s_fdata), .cpu_rst(s_cpu_rst), .busy(s_busy), .load_count(s_cnt),
    .err_align(s_ea), .err_range(s_er)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } fvec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic fchk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    fetch_addr = addr;
    #1;
    chk(name, fetch_data, exp);
  endtask

  task automatic ld(input logic auto_m, input logic [31:0] addr, input logic [31:0] data);
    ld_auto  = auto_m;
    ld_addr  = addr;
    ld_data  = data;
    ld_valid = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Cycles until cpu_rst falls, bounded.
  task automatic wait_run(output int n);
    n = 0;
    while (cpu_rst && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_all_zero(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < 256; a += 4) begin
      @(negedge clk);
      fetch_addr = 32'(a);
      #1;
      if (fetch_data !== 32'h0) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fvec_t tbl[9];
    int    n;

    tbl[0] = '{32'd0,   32'h00044022};
    tbl[1] = '{32'd4,   32'h0100202A};
    tbl[2] = '{32'd8,   32'h2022FFB8};
    tbl[3] = '{32'd12,  32'h00000000};
    tbl[4] = '{32'd28,  32'h00000000};
    tbl[5] = '{32'd32,  32'h3C090009};
    tbl[6] = '{32'd35,  32'h3C090009};
    tbl[7] = '{32'd252, 32'h00000000};
    tbl[8] = '{32'd256, 32'h00000000};

    rst = 1'b1; initialize = 1'b1; ld_valid = 1'b0; ld_auto = 1'b0;
    ld_addr = '0; ld_data = '0; fetch_addr = '0;
    s_rst = 1'b1; s_init = 1'b0; s_valid = 1'b0; s_auto = 1'b1;
    s_addr = '0; s_data = '0; s_fetch = '0;

    repeat (2) @(negedge clk);
    chk("rst_cpu_rst",    32'(cpu_rst),    32'd1);
    chk("rst_busy",       32'(busy),       32'd1);
    chk("rst_ld_ready",   32'(ld_ready),   32'd0);
    chk("rst_fetch",      fetch_data,      32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_err_align",  32'(err_align),  32'd0);
    chk("rst_err_range",  32'(err_range),  32'd0);

    // Clear takes DEPTH cycles before LOAD opens
    rst = 1'b0;
    repeat (63) @(negedge clk);
    chk("clear_not_ready_63", 32'(ld_ready), 32'd0);
    @(negedge clk);
    chk("load_ready_64", 32'(ld_ready), 32'd1);

    // Fill every word with all-ones so the later clear is visible
    ld_auto = 1'b1; ld_data = 32'hFFFFFFFF; ld_valid = 1'b1;
    repeat (64) @(negedge clk);
    ld_valid = 1'b0;
    chk("fill_count", 32'(load_count), 32'd64);
    initialize = 1'b0;
    wait_run(n);
    chk("fill_hold_cycles", 32'(n), 32'd5);
    fchk("fill_word63", 32'd252, 32'hFFFFFFFF);

    // Reset, initialize low: DEPTH + HOLD_CYCLES cycles of cpu_rst, memory zeroed
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_cpu_rst",    32'(cpu_rst),    32'd1);
    chk("rst2_fetch",      fetch_data,      32'd0);
    chk("rst2_load_count", 32'(load_count), 32'd0);
    rst = 1'b0;
    wait_run(n);
    chk("clear_hold_cycles", 32'(n), 32'd68);
    chk("run_busy", 32'(busy), 32'd0);
    chk_all_zero("clear_all_zero");

    // Explicit load with a gap
    @(negedge clk);
    initialize = 1'b1;
    @(negedge clk);
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_busy",    32'(busy),    32'd1);
    ld(1'b0, 32'd0,  32'h00044022);
    ld(1'b0, 32'd4,  32'h0100202A);
    ld(1'b0, 32'd8,  32'h2022FFB8);
    ld(1'b0, 32'd32, 32'h3C090009);
    initialize = 1'b0;
    wait_run(n);
    chk("explicit_hold_cycles", 32'(n), 32'd5);
    chk("explicit_count", 32'(load_count), 32'd4);
    for (int i = 0; i < 9; i++) fchk($sformatf("explicit_fetch_%0d", tbl[i].addr), tbl[i].addr, tbl[i].exp);

    // Auto mode with valid on every other cycle
    @(negedge clk);
    initialize = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ld(1'b1, 32'h0, 32'hA0000000 + 32'(i));
      @(negedge clk);
    end
    chk("auto_count", 32'(load_count), 32'd5);
    initialize = 1'b0;
    wait_run(n);
    for (int i = 0; i < 5; i++) fchk($sformatf("auto_fetch_%0d", 4 * i), 32'(4 * i), 32'hA0000000 + 32'(i));
    fchk("auto_fetch_20", 32'd20, 32'h0);
    fchk("auto_kept_32",  32'd32, 32'h3C090009);

    // Misaligned and out-of-range explicit writes are dropped
    @(negedge clk);
    initialize = 1'b1;
    @(negedge clk);
    ld(1'b0, 32'd6, 32'hDEADBEEF);
    chk("align_flag",       32'(err_align),  32'd1);
    chk("align_range_flag", 32'(err_range),  32'd0);
    chk("align_count",      32'(load_count), 32'd0);
    ld(1'b0, 32'd256, 32'hDEADBEEF);
    chk("range_flag", 32'(err_range), 32'd1);
    ld(1'b0, 32'h80000000, 32'hDEADBEEF);
    chk("range_count", 32'(load_count), 32'd0);
    initialize = 1'b0;
    wait_run(n);
    fchk("align_mem1_kept", 32'd4, 32'hA0000001);
    fchk("range_mem0_kept", 32'd0, 32'hA0000000);

    // Re-load from RUN: fetch gated, flags sticky, untouched words kept
    @(negedge clk);
    fetch_addr = 32'd0;
    initialize = 1'b1;
    @(negedge clk);
    #1;
    chk("reload2_cpu_rst", 32'(cpu_rst),   32'd1);
    chk("reload2_fetch",   fetch_data,     32'd0);
    chk("sticky_align",    32'(err_align), 32'd1);
    chk("sticky_range",    32'(err_range), 32'd1);
    ld(1'b0, 32'd4, 32'h00223820);
    initialize = 1'b0;
    wait_run(n);
    chk("reload2_count", 32'(load_count), 32'd1);
    fchk("reload2_new_4", 32'd4, 32'h00223820);
    fchk("reload2_old_0", 32'd0, 32'hA0000000);

    // Reset in the middle of a load handshake
    @(negedge clk);
    initialize = 1'b1;
    @(negedge clk);
    ld_auto = 1'b1; ld_data = 32'h12345678; ld_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; rst = 1'b0; initialize = 1'b0;
    chk("midrst_align",   32'(err_align),  32'd0);
    chk("midrst_range",   32'(err_range),  32'd0);
    chk("midrst_count",   32'(load_count), 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst),    32'd1);
    chk("midrst_ready",   32'(ld_ready),   32'd0);
    wait_run(n);
    chk("midrst_hold_cycles", 32'(n), 32'd68);
    chk_all_zero("midrst_all_zero");

    // DEPTH=4 build: auto pointer runs past the end
    @(negedge clk);
    s_init = 1'b1; s_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("s_clear_not_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("s_load_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      s_data = 32'hB0000000 + 32'(i);
      s_valid = 1'b1;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("s_err_range", 32'(s_er),  32'd1);
    chk("s_err_align", 32'(s_ea),  32'd0);
    chk("s_count",     32'(s_cnt), 32'd4);
    s_init = 1'b0;
    n = 0;
    while (s_cpu_rst && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s_hold_cycles", 32'(n), 32'd3);
    chk("s_busy", 32'(s_busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_fetch = 32'(4 * i);
      #1;
      chk($sformatf("s_fetch_%0d", 4 * i), s_fdata, (i < 4) ? 32'hB0000000 + 32'(i) : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
